// File: rtl/uartlite_pkg.sv
// Shared definitions for the AXI UART Lite register map.
// Register byte offsets, status/control bit meanings, AXI response codes and
// the transmit-writer state encoding. Intended for reuse by the receive-side
// reader as well.
package uartlite_pkg;

    // Register offsets inside the UART Lite AXI4-Lite window
    localparam logic [3:0] REG_RX   = 4'h0;
    localparam logic [3:0] REG_TX   = 4'h4;
    localparam logic [3:0] REG_STAT = 4'h8;
    localparam logic [3:0] REG_CTRL = 4'hC;

    // Status register bit positions
    localparam int STAT_TXFULL  = 3;
    localparam int STAT_TXEMPTY = 2;

    // Control register values
    localparam logic [31:0] CTRL_RST_TX = 32'h0000_0001;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Transmit writer FSM states
    typedef enum logic [2:0] {
        ST_INIT_AW,
        ST_INIT_B,
        ST_IDLE,
        ST_RD_A,
        ST_RD_D,
        ST_GAP,
        ST_WR,
        ST_WR_B
    } state_t;

endpackage

// File: rtl/uartlite_axi_writer_if.sv
// AXI4-Lite bus between the transmit writer (master) and the UART Lite (slave).
// Signals:
//   write address : m_axi_awaddr, m_axi_awvalid, m_axi_awready
//   write data    : m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready
//   write response: m_axi_bresp, m_axi_bvalid, m_axi_bready
//   read address  : m_axi_araddr, m_axi_arvalid, m_axi_arready
//   read data     : m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rready
interface uartlite_axi_writer_if;
    import uartlite_pkg::*;

    logic [3:0]  m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [3:0]  m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        output m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
        input  m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

endinterface

// File: rtl/uartlite_axi_writer.sv
// Byte-stream to AXI UART Lite TX FIFO writer.
// Accepts bytes on a valid/ready stream; for each byte it polls the status
// register until the TX FIFO is not full, then writes the byte to the TX FIFO.
// Optionally resets the TX FIFO once after reset.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   data_i, valid_i    : input byte stream
//   ready_o            : byte accepted on valid_i & ready_o
//   busy_o             : FSM not idle
//   err_o              : sticky, set by any non-OKAY read or write response
//   tx_count_o         : bytes written with an OKAY response (wraps)
//   axi                : AXI4-Lite master port towards the UART Lite
module uartlite_axi_writer
    import uartlite_pkg::*;
#(
    parameter int POLL_GAP          = 4,
    parameter bit CLEAR_TX_ON_START = 1'b1,
    parameter int CNT_W             = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [CNT_W-1:0]      tx_count_o,
    uartlite_axi_writer_if.master axi
);

    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (POLL_GAP > 0) ? GAP_W'(POLL_GAP - 1) : '0;
    localparam state_t RESET_STATE = CLEAR_TX_ON_START ? ST_INIT_AW : ST_IDLE;

    state_t             state_reg, state_next;
    logic [7:0]         byte_reg;
    logic               aw_done_reg, aw_done_next;
    logic               w_done_reg, w_done_next;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               err_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               ready_reg;
    logic               busy_reg;
    // Holds the init write off the bus while reset is asserted, so every
    // valid is low during reset even though the state is already INIT_AW.
    logic               armed_reg;

    logic aw_hs, w_hs, accept, rd_err, wr_err, wr_ok;
    logic unused_rdata;

    assign aw_hs  = axi.m_axi_awvalid & axi.m_axi_awready;
    assign w_hs   = axi.m_axi_wvalid & axi.m_axi_wready;
    assign accept = (state_reg == ST_IDLE) & valid_i & ready_reg;
    assign rd_err = (state_reg == ST_RD_D) & axi.m_axi_rvalid & (axi.m_axi_rresp != RESP_OKAY);
    assign wr_err = ((state_reg == ST_WR_B) | (state_reg == ST_INIT_B))
                    & axi.m_axi_bvalid & (axi.m_axi_bresp != RESP_OKAY);
    assign wr_ok  = (state_reg == ST_WR_B) & axi.m_axi_bvalid & (axi.m_axi_bresp == RESP_OKAY);

    // Only the TX-full flag matters for flow control.
    assign unused_rdata = ^{axi.m_axi_rdata[31:STAT_TXFULL+1], axi.m_axi_rdata[STAT_TXFULL-1:0]};

    assign ready_o    = ready_reg;
    assign busy_o     = busy_reg;
    assign err_o      = err_reg;
    assign tx_count_o = count_reg;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= RESET_STATE;
            byte_reg    <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            gap_cnt_reg <= '0;
            err_reg     <= 1'b0;
            count_reg   <= '0;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            aw_done_reg <= aw_done_next;
            w_done_reg  <= w_done_next;
            armed_reg   <= 1'b1;
            // Registered from the next state so they line up with state_reg.
            ready_reg   <= (state_next == ST_IDLE);
            busy_reg    <= (state_next != ST_IDLE);
            gap_cnt_reg <= (state_reg == ST_GAP) ? gap_cnt_reg + 1'b1 : '0;
            if (accept) begin
                byte_reg <= data_i;
            end
            if (rd_err || wr_err) begin
                err_reg <= 1'b1;
            end
            if (wr_ok) begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state_reg;
        aw_done_next = aw_done_reg;
        w_done_next  = w_done_reg;
        case (state_reg)
            ST_INIT_AW, ST_WR: begin
                // Address and data channels complete independently.
                aw_done_next = aw_done_reg | aw_hs;
                w_done_next  = w_done_reg | w_hs;
                if (aw_done_next && w_done_next) begin
                    state_next   = (state_reg == ST_INIT_AW) ? ST_INIT_B : ST_WR_B;
                    aw_done_next = 1'b0;
                    w_done_next  = 1'b0;
                end
            end
            ST_INIT_B: begin
                if (axi.m_axi_bvalid) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_RD_A;
                end
            end
            ST_RD_A: begin
                if (axi.m_axi_arready) begin
                    state_next = ST_RD_D;
                end
            end
            ST_RD_D: begin
                if (axi.m_axi_rvalid) begin
                    if (axi.m_axi_rresp != RESP_OKAY) begin
                        state_next = ST_IDLE;
                    end else if (axi.m_axi_rdata[STAT_TXFULL]) begin
                        state_next = (POLL_GAP == 0) ? ST_RD_A : ST_GAP;
                    end else begin
                        state_next = ST_WR;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    state_next = ST_RD_A;
                end
            end
            ST_WR_B: begin
                if (axi.m_axi_bvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus outputs decoded from the state; valids follow the async state reset.
    always_comb begin
        axi.m_axi_awaddr  = '0;
        axi.m_axi_awvalid = 1'b0;
        axi.m_axi_wdata   = '0;
        axi.m_axi_wstrb   = '0;
        axi.m_axi_wvalid  = 1'b0;
        axi.m_axi_bready  = 1'b0;
        axi.m_axi_araddr  = '0;
        axi.m_axi_arvalid = 1'b0;
        axi.m_axi_rready  = 1'b0;
        case (state_reg)
            ST_INIT_AW: begin
                axi.m_axi_awaddr  = REG_CTRL;
                axi.m_axi_awvalid = armed_reg & ~aw_done_reg;
                axi.m_axi_wdata   = CTRL_RST_TX;
                axi.m_axi_wstrb   = 4'b0001;
                axi.m_axi_wvalid  = armed_reg & ~w_done_reg;
            end
            ST_WR: begin
                axi.m_axi_awaddr  = REG_TX;
                axi.m_axi_awvalid = ~aw_done_reg;
                axi.m_axi_wdata   = {24'h0, byte_reg};
                axi.m_axi_wstrb   = 4'b0001;
                axi.m_axi_wvalid  = ~w_done_reg;
            end
            ST_INIT_B, ST_WR_B: begin
                axi.m_axi_bready = 1'b1;
            end
            ST_RD_A: begin
                axi.m_axi_araddr  = REG_STAT;
                axi.m_axi_arvalid = 1'b1;
            end
            ST_RD_D: begin
                axi.m_axi_rready = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
